// File: rtl/mem_access_unit.sv
// MEM-stage byte serialiser: splits one byte/half/word load or store into
// single-byte arbiter requests and reassembles load bytes little-endian.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  write_i,
  input  logic [1:0]            size_i,
  input  logic                  signed_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [7:0]            mem_din_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [7:0]            mem_data_o,
  output logic [31:0]           rdata_o,
  output logic                  done_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state_q;
  logic                  write_q;
  logic                  signed_q;
  logic [1:0]            last_q;
  logic [1:0]            k_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [7:0]            lbuf_q [4];

  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [7:0]            mem_data_q;
  logic [31:0]           rdata_q;
  logic                  done_q;
  logic                  busy_q;

  logic [1:0]            k_d;
  logic [1:0]            kprev_d;
  logic [1:0]            last_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [7:0]            wbyte_d;
  logic [31:0]           raw_d;
  logic [31:0]           ext_d;

  assign k_d     = k_q + 2'd1;
  assign kprev_d = k_q - 2'd1;
  assign addr_d  = base_q + ADDR_WIDTH'(k_d);
  assign wbyte_d = wdata_q[{k_d, 3'b000} +: 8];

  // Index of the final byte: 0 for byte, 1 for half, 3 for word and reserved.
  always_comb begin
    last_d = 2'd3;
    case (size_i)
      2'b00:   last_d = 2'd0;
      2'b01:   last_d = 2'd1;
      default: last_d = 2'd3;
    endcase
  end

  // The final load byte is still on mem_din_i during DRAIN, so splice it in directly.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign raw_d[8*gi +: 8] = (last_q == 2'(gi)) ? mem_din_i : lbuf_q[gi];
    end
  endgenerate

  always_comb begin
    ext_d = raw_d;
    case (last_q)
      2'd0:    ext_d = {{24{signed_q & raw_d[7]}}, raw_d[7:0]};
      2'd1:    ext_d = {{16{signed_q & raw_d[15]}}, raw_d[15:0]};
      default: ext_d = raw_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      last_q     <= 2'd0;
      k_q        <= 2'd0;
      base_q     <= '0;
      wdata_q    <= 32'd0;
      for (int i = 0; i < 4; i++) lbuf_q[i] <= 8'd0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= 8'd0;
      rdata_q    <= 32'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            write_q    <= write_i;
            signed_q   <= signed_i;
            last_q     <= last_d;
            base_q     <= addr_i;
            wdata_q    <= wdata_i;
            k_q        <= 2'd0;
            mem_req_q  <= 1'b1;
            mem_we_q   <= write_i;
            mem_addr_q <= addr_i;
            mem_data_q <= write_i ? wdata_i[7:0] : 8'd0;
            busy_q     <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Byte k-1 returns while byte k is being addressed.
          if (!write_q && (k_q != 2'd0)) lbuf_q[kprev_d] <= mem_din_i;
          if (k_q == last_q) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= 8'd0;
            if (write_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_DRAIN;
            end
          end else begin
            k_q        <= k_d;
            mem_addr_q <= addr_d;
            mem_data_q <= write_q ? wbyte_d : 8'd0;
          end
        end
        S_DRAIN: begin
          rdata_q <= ext_d;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign rdata_o    = rdata_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, reset/hold sequences and random
// accesses against a byte-addressed reference memory.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_i;
  logic        write_i;
  logic [1:0]  size_i;
  logic        signed_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [7:0]  mem_din_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_o;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        busy_o;

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .write_i(write_i), .size_i(size_i),
    .signed_i(signed_i), .addr_i(addr_i), .wdata_i(wdata_i), .mem_din_i(mem_din_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .rdata_o(rdata_o), .done_o(done_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        wr;
    bit [1:0]  size;
    bit        sgn;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] exp;
  } vec_t;

  bit [7:0] bus_mem [bit [31:0]];
  bit [7:0] ref_mem [bit [31:0]];
  int n_chk  = 0;
  int n_pass = 0;
  bit [31:0] last_rdata = 32'd0;

  function automatic bit [7:0] bus_rd(bit [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : 8'd0;
  endfunction

  function automatic bit [7:0] ref_rd(bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'd0;
  endfunction

  // Arbiter/RAM stand-in: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_req_o && mem_we_o) bus_mem[mem_addr_o] = mem_data_o;
    if (mem_req_o && !mem_we_o) mem_din_i <= bus_rd(mem_addr_o);
    else mem_din_i <= 8'($urandom);
  end

  function automatic void chk(string nm, int cyc, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endfunction

  function automatic int nbytes(bit [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit [31:0] model_load(vec_t v);
    int n = nbytes(v.size);
    bit [63:0] val = 64'd0;
    for (int k = 0; k < n; k++) val |= 64'(ref_rd(v.addr + 32'(k))) << (8 * k);
    if (v.sgn && n < 4 && val[8*n-1]) val |= ~((64'd1 << (8 * n)) - 64'd1);
    return val[31:0];
  endfunction

  function automatic void ref_store(vec_t v);
    for (int k = 0; k < nbytes(v.size); k++) ref_mem[v.addr + 32'(k)] = 8'(v.wdata >> (8 * k));
  endfunction

  function automatic void preload(bit [31:0] a, bit [7:0] d);
    bus_mem[a] = d;
    ref_mem[a] = d;
  endfunction

  // Entered at a negedge with the DUT idle; returns at the negedge of the
  // cycle right after done_o, which is the next access's accept cycle.
  task automatic run(input vec_t v, input vec_t nxt, input bit chain, input string nm);
    int n = nbytes(v.size);
    int done_c = v.wr ? n + 1 : n + 2;
    req_i = 1'b1; write_i = v.wr; size_i = v.size; signed_i = v.sgn;
    addr_i = v.addr; wdata_i = v.wdata;
    @(negedge clk);
    if (chain) begin
      write_i = nxt.wr; size_i = nxt.size; signed_i = nxt.sgn;
      addr_i = nxt.addr; wdata_i = nxt.wdata;
    end else begin
      req_i = 1'b0; write_i = 1'($urandom); size_i = 2'($urandom);
      signed_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom;
    end
    for (int c = 1; c <= done_c; c++) begin
      bit in_iss = (c <= n);
      bit [31:0] k = 32'(c - 1);
      chk({nm, " mem_req"}, c, 32'(mem_req_o), 32'(in_iss));
      chk({nm, " mem_addr"}, c, mem_addr_o, in_iss ? v.addr + k : 32'd0);
      chk({nm, " mem_we"}, c, 32'(mem_we_o), 32'(in_iss & v.wr));
      chk({nm, " mem_data"}, c, 32'(mem_data_o),
          (in_iss && v.wr) ? ((v.wdata >> (8 * k)) & 32'hFF) : 32'd0);
      chk({nm, " busy"}, c, 32'(busy_o), 32'd1);
      chk({nm, " done"}, c, 32'(done_o), 32'(c == done_c));
      if (c == done_c) chk({nm, " rdata"}, c, rdata_o, v.exp);
      @(negedge clk);
    end
    chk({nm, " done_after"}, done_c + 1, 32'(done_o), 32'd0);
    chk({nm, " busy_after"}, done_c + 1, 32'(busy_o), 32'd0);
    chk({nm, " rdata_held"}, done_c + 1, rdata_o, v.exp);
    if (v.wr)
      for (int k = 0; k < n; k++)
        chk({nm, " ram_byte"}, k, 32'(bus_rd(v.addr + 32'(k))), (v.wdata >> (8 * k)) & 32'hFF);
    $display("txn %s wr=%0d size=%0d sgn=%0d addr=%h wdata=%h rdata=%h", nm, v.wr, v.size,
             v.sgn, v.addr, v.wdata, rdata_o);
  endtask

  task automatic chk_all_zero(string nm, int cyc);
    chk({nm, " mem_req"}, cyc, 32'(mem_req_o), 32'd0);
    chk({nm, " mem_we"}, cyc, 32'(mem_we_o), 32'd0);
    chk({nm, " mem_addr"}, cyc, mem_addr_o, 32'd0);
    chk({nm, " mem_data"}, cyc, 32'(mem_data_o), 32'd0);
    chk({nm, " rdata"}, cyc, rdata_o, 32'd0);
    chk({nm, " done"}, cyc, 32'(done_o), 32'd0);
    chk({nm, " busy"}, cyc, 32'(busy_o), 32'd0);
  endtask

  vec_t tbl [8];
  vec_t v, w;

  initial begin
    rst = 1'b1; req_i = 1'b0; write_i = 1'b0; size_i = 2'b00; signed_i = 1'b0;
    addr_i = 32'd0; wdata_i = 32'd0;
    preload(32'h1000, 8'h11); preload(32'h1001, 8'h22);
    preload(32'h1002, 8'h33); preload(32'h1003, 8'h44);
    preload(32'h20, 8'h80); preload(32'h30, 8'h01); preload(32'h31, 8'h80);
    for (int i = 0; i < 20; i++) preload(32'h100 + 32'(i), 8'($urandom));
    for (int i = 0; i < 4; i++) preload(32'hFFFF_FFFC + 32'(i), 8'($urandom));
    for (int i = 0; i < 4; i++) preload(32'(i), 8'($urandom));

    //          wr    size   sgn   addr           wdata          exp rdata
    tbl[0] = '{1'b0, 2'b10, 1'b0, 32'h1000,      32'h0,         32'h4433_2211};
    tbl[1] = '{1'b0, 2'b00, 1'b1, 32'h20,        32'h0,         32'hFFFF_FF80};
    tbl[2] = '{1'b0, 2'b00, 1'b0, 32'h20,        32'h0,         32'h0000_0080};
    tbl[3] = '{1'b0, 2'b01, 1'b1, 32'h30,        32'h0,         32'hFFFF_8001};
    tbl[4] = '{1'b0, 2'b01, 1'b0, 32'h30,        32'h0,         32'h0000_8001};
    tbl[5] = '{1'b1, 2'b10, 1'b0, 32'h2000,      32'hDEAD_BEEF, 32'h0000_8001};
    tbl[6] = '{1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_A55A, 32'h0000_8001};
    tbl[7] = '{1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_A55A};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset", 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      run(tbl[i], tbl[i], 1'b0, $sformatf("tbl%0d", i));
      if (tbl[i].wr) ref_store(tbl[i]);
    end
    last_rdata = tbl[7].exp;

    // Reset during cycle 2 of a word load.
    req_i = 1'b1; write_i = 1'b0; size_i = 2'b10; signed_i = 1'b0; addr_i = 32'h1000;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_mid", 3);
    rst = 1'b0;
    for (int c = 4; c < 8; c++) begin
      @(negedge clk);
      chk("rst_mid done", c, 32'(done_o), 32'd0);
      chk("rst_mid mem_req", c, 32'(mem_req_o), 32'd0);
    end
    run(tbl[0], tbl[0], 1'b0, "after_rst");

    // Back-to-back with req_i held; reserved size acts as a word.
    v = '{1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, 32'h4433_2211};
    w = '{1'b0, 2'b00, 1'b0, 32'h20,   32'h0, 32'h0000_0080};
    run(v, w, 1'b1, "hold_first");
    run(w, w, 1'b0, "hold_second");
    last_rdata = w.exp;

    for (int i = 0; i < 40; i++) begin
      v.wr    = 1'($urandom);
      v.size  = 2'($urandom);
      v.sgn   = 1'($urandom);
      v.addr  = $urandom_range(0, 1) ? 32'h100 + 32'($urandom_range(0, 15))
                                     : 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      v.wdata = $urandom;
      v.exp   = v.wr ? last_rdata : model_load(v);
      run(v, v, 1'b0, $sformatf("rnd%0d", i));
      if (v.wr) ref_store(v);
      last_rdata = v.exp;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
